// File: rtl/dac_pkg.sv
// Shared constants and FSM encoding for the DAC slew driver.
package dac_pkg;

    localparam int DAC_W    = 14;
    localparam int STEP_MIN = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data: rd_data updates on the cycle after pop.
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Flags come from the registered count, so a pop never frees a slot in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dac_slew_driver.sv
// Queues DAC target codes and walks dac_data toward each one in slew-limited steps,
// one step per update tick.
module dac_slew_driver
    import dac_pkg::*;
#(
    parameter int N     = DAC_W,
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [N-1:0] tgt_data,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic [N-1:0] step,
    output logic [N-1:0] dac_data,
    output logic         dac_wr,
    output logic         busy,
    output logic         settled
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   div_cnt;
    logic            tick;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [N-1:0]    fifo_rd_data;
    logic            load_en;
    logic            wr_en;
    logic [N-1:0]    cur_tgt;
    logic [N-1:0]    cur_step;
    logic signed [N:0] diff;
    logic [N:0]      mag;
    logic            close;

    // Handshake: a target is taken on any edge where tgt_valid && tgt_ready; while
    // tgt_ready is low the source must hold tgt_data stable and keep tgt_valid high.
    assign tgt_ready = !fifo_full;

    sync_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .push    (tgt_valid),
        .wr_data (tgt_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Distance to target at N+1 bits so the sign is never lost.
    assign diff  = $signed({1'b0, cur_tgt}) - $signed({1'b0, dac_data});
    assign mag   = diff[N] ? -diff : diff;
    assign close = (mag <= {1'b0, cur_step});

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        load_en    = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                load_en    = 1'b1;
                next_state = RAMP;
            end
            RAMP: begin
                if (tick) begin
                    wr_en = 1'b1;
                    if (close) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            dac_data <= '0;
            dac_wr   <= 1'b0;
            cur_tgt  <= '0;
            cur_step <= N'(STEP_MIN);
        end else begin
            dac_wr <= wr_en;
            if (load_en) begin
                cur_tgt  <= fifo_rd_data;
                cur_step <= (step == '0) ? N'(STEP_MIN) : step;
            end
            // Clamping to cur_tgt when within one step keeps the code inside its range.
            if (wr_en) begin
                if (close) begin
                    dac_data <= cur_tgt;
                end else if (diff[N]) begin
                    dac_data <= dac_data - cur_step;
                end else begin
                    dac_data <= dac_data + cur_step;
                end
            end
        end
    end

    assign busy    = (state != IDLE) || !fifo_empty;
    assign settled = (state == IDLE) && fifo_empty;

endmodule
